// File: rtl/etc_semiring_tile.sv
// N x N semiring tile: C op= A (x) B across a chain of K-tiles; last beat accepted at edge t gives out_valid after t+1.
// One global enable stalls input, stage 1, accumulator and output together whenever the held result is not taken.
module etc_semiring_tile #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [N*N*W-1:0]   inA,
  input  logic [N*N*W-1:0]   inB,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*N*W-1:0]   out_data,
  output logic               out_ovf
);

  localparam int TW = N*N*W;

  // Element helpers return {flag, value}; flag marks a wrap or a saturation.
  function automatic logic [W:0] f_times(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [W:0]     sum;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sum  = {1'b0, a} + {1'b0, b};
    case (op)
      3'd1, 3'd2: f_times = sum[W] ? {1'b1, {W{1'b1}}} : sum;
      3'd3:       f_times = {1'b0, (a > b) ? a : b};
      3'd4:       f_times = {1'b0, (a < b) ? a : b};
      3'd5:       f_times = {1'b0, a & b};
      default:    f_times = {|prod[2*W-1:W], prod[W-1:0]};
    endcase
  endfunction

  function automatic logic [W:0] f_plus(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    case (op)
      3'd1, 3'd3: f_plus = {1'b0, (a < b) ? a : b};
      3'd2, 3'd4: f_plus = {1'b0, (a > b) ? a : b};
      3'd5:       f_plus = {1'b0, a | b};
      default:    f_plus = sum;
    endcase
  endfunction

  function automatic logic [W-1:0] f_ident(input logic [2:0] op);
    f_ident = (op == 3'd1 || op == 3'd3) ? {W{1'b1}} : {W{1'b0}};
  endfunction

  function automatic logic [W:0] f_elem(input logic [2:0] op, input logic first,
                                        input logic [TW-1:0] a_t, input logic [TW-1:0] b_t,
                                        input logic [W-1:0] acc_e, input int i, input int j);
    logic [W-1:0] r;
    logic [W:0]   t;
    logic         fl;
    r  = f_ident(op);
    fl = 1'b0;
    for (int k = 0; k < N; k++) begin
      t  = f_times(op, a_t[(i*N+k)*W +: W], b_t[(k*N+j)*W +: W]);
      fl = fl | t[W];
      t  = f_plus(op, r, t[W-1:0]);
      fl = fl | t[W];
      r  = t[W-1:0];
    end
    t  = f_plus(op, first ? f_ident(op) : acc_e, r);
    fl = fl | t[W];
    f_elem = {fl, t[W-1:0]};
  endfunction

  logic            en;
  logic            chain_active;
  logic [2:0]      chain_op;
  logic            eff_first;
  logic            s1_v, s1_first, s1_last;
  logic [2:0]      s1_op;
  logic [TW-1:0]   s1_a, s1_b;
  logic [TW-1:0]   acc, nxt_acc;
  logic            acc_ovf, step_ovf, nxt_ovf;
  logic [W:0]      elem;

  assign en        = !(out_valid && !out_ready);
  assign in_ready  = en;
  // A continuation beat with no open chain silently starts one.
  assign eff_first = in_first || !chain_active;

  always_comb begin
    nxt_acc  = '0;
    step_ovf = 1'b0;
    elem     = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        elem = f_elem(s1_op, s1_first, s1_a, s1_b, acc[(i*N+j)*W +: W], i, j);
        nxt_acc[(i*N+j)*W +: W] = elem[W-1:0];
        step_ovf = step_ovf | elem[W];
      end
    end
  end

  assign nxt_ovf = step_ovf | (s1_first ? 1'b0 : acc_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_active <= 1'b0;
      chain_op     <= '0;
      s1_v         <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_op        <= '0;
      s1_a         <= '0;
      s1_b         <= '0;
      acc          <= '0;
      acc_ovf      <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ovf      <= 1'b0;
    end else if (en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a         <= inA;
        s1_b         <= inB;
        s1_first     <= eff_first;
        s1_last      <= in_last;
        s1_op        <= eff_first ? in_op : chain_op;
        chain_active <= !in_last;
        if (eff_first) chain_op <= in_op;
      end
      if (s1_v) begin
        acc     <= nxt_acc;
        acc_ovf <= nxt_ovf;
        if (s1_last) begin
          out_data <= nxt_acc;
          out_ovf  <= nxt_ovf;
        end
      end
      // A taken result is replaced by a new last beat on the same edge, else it drops.
      out_valid <= s1_v && s1_last;
    end
  end

endmodule

// File: tb/tb_etc_semiring_tile.sv
// Directed-vector bench for etc_semiring_tile (N=4, W=16): table of single-tile beats plus chain, stall and reset sequences.
module tb_etc_semiring_tile;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TW = N*N*W;
  typedef logic [TW-1:0] tile_t;

  typedef struct {
    logic [2:0] op;
    int         pa;
    int         pb;
    int         pe;
    logic       ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  tile_t       inA = '0;
  tile_t       inB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  tile_t       out_data;
  logic        out_ovf;

  int checks = 0;
  int failures = 0;

  etc_semiring_tile #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_first(in_first), .in_last(in_last), .inA(inA), .inB(inB), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  // Element patterns; expected tiles below were worked out by hand from these.
  function automatic logic [15:0] pat(input int p, input int i, input int j);
    logic [15:0] v;
    v = 16'hFFFF;
    case (p)
      0:  v = (i == j) ? 16'd1 : 16'd0;
      1:  v = 16'(4*i + j);
      2:  v = 16'd1;
      3:  v = 16'h0100;
      4:  v = 16'h8000;
      5:  begin
            if (i == j) v = 16'd0;
            else if (j == i + 1) v = (i == 0) ? 16'd3 : (i == 1) ? 16'd5 : 16'd2;
          end
      6:  begin
            if (i == j) v = 16'd0;
            else if (i == 0 && j == 1) v = 16'd3;
            else if (i == 0 && j == 2) v = 16'd8;
            else if (i == 1 && j == 2) v = 16'd5;
            else if (i == 1 && j == 3) v = 16'd7;
            else if (i == 2 && j == 3) v = 16'd2;
          end
      7:  if (i == 0 && j == 1) v = 16'hFFF0;
      8:  if (i == 1 && j == 0) v = 16'h0020;
      9:  v = 16'hFFFF;
      10: v = 16'hFFFE;
      11: v = 16'(i + j);
      12: v = 16'(i * j);
      13: v = 16'(i + 3 + 3*j);
      14: v = 16'(i);
      15: v = 16'(j);
      16: v = 16'((i < j) ? i : j);
      17: v = 16'((i > j) ? i : j);
      18: v = 16'(1 << j);
      19: v = 16'((1 << j) | 16);
      20: v = 16'(4*i + j + 1);
      22: v = 16'd0;
      23: v = 16'd12;
      24: v = 16'd4;
      26: v = 16'((1 << j) | 1);
      default: v = 16'hDEAD;
    endcase
    return v;
  endfunction

  function automatic tile_t tile(input int p);
    tile_t t;
    t = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        t[(i*N+j)*W +: W] = pat(p, i, j);
    return t;
  endfunction

  // Reference for ops 3 (min,max) and 5 (or,and); anything else is treated as 5.
  function automatic tile_t model(input logic [2:0] op, input tile_t a, input tile_t b,
                                  input tile_t acc, input logic first);
    tile_t res;
    logic [15:0] r, x, y, m, base;
    res = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        r = (op == 3'd3) ? 16'hFFFF : 16'h0000;
        for (int k = 0; k < N; k++) begin
          x = a[(i*N+k)*W +: W];
          y = b[(k*N+j)*W +: W];
          if (op == 3'd3) begin
            m = (x > y) ? x : y;
            if (m < r) r = m;
          end else begin
            r = r | (x & y);
          end
        end
        base = first ? ((op == 3'd3) ? 16'hFFFF : 16'h0000) : acc[(i*N+j)*W +: W];
        if (op == 3'd3) res[(i*N+j)*W +: W] = (base < r) ? base : r;
        else            res[(i*N+j)*W +: W] = base | r;
      end
    end
    return res;
  endfunction

  task automatic chk(input string nm, input tile_t act, input tile_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input string nm, input tile_t e, input logic eo);
    chk({nm, " out_valid"}, tile_t'(out_valid), tile_t'(1));
    chk({nm, " out_data"}, out_data, e);
    chk({nm, " out_ovf"}, tile_t'(out_ovf), tile_t'(eo));
  endtask

  task automatic expect_none(input string nm);
    chk({nm, " no out_valid"}, tile_t'(out_valid), tile_t'(0));
  endtask

  task automatic drive(input logic [2:0] op, input logic f, input logic l,
                       input tile_t a, input tile_t b);
    in_valid = 1'b1;
    in_op    = op;
    in_first = f;
    in_last  = l;
    inA      = a;
    inB      = b;
  endtask

  vec_t  vt[14];
  tile_t ra[8], rb[8];
  tile_t e1, e2;

  initial begin
    vt[0]  = '{3'd0, 0, 1, 1, 1'b0};
    vt[1]  = '{3'd0, 2, 2, 24, 1'b0};
    vt[2]  = '{3'd0, 3, 3, 22, 1'b1};
    vt[3]  = '{3'd0, 4, 2, 22, 1'b1};
    vt[4]  = '{3'd1, 5, 5, 6, 1'b1};
    vt[5]  = '{3'd1, 7, 8, 9, 1'b1};
    vt[6]  = '{3'd1, 10, 2, 9, 1'b0};
    vt[7]  = '{3'd2, 11, 12, 13, 1'b0};
    vt[8]  = '{3'd2, 9, 2, 9, 1'b1};
    vt[9]  = '{3'd3, 14, 15, 17, 1'b0};
    vt[10] = '{3'd4, 14, 15, 16, 1'b0};
    vt[11] = '{3'd5, 18, 19, 18, 1'b0};
    vt[12] = '{3'd6, 0, 20, 20, 1'b0};
    vt[13] = '{3'd7, 3, 3, 22, 1'b1};

    // Reset state.
    #12;
    chk("reset in_ready", tile_t'(in_ready), tile_t'(1));
    chk("reset out_valid", tile_t'(out_valid), tile_t'(0));
    chk("reset out_data", out_data, '0);
    chk("reset out_ovf", tile_t'(out_ovf), tile_t'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single-tile beats back to back: each result two edges after its beat.
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      if (v >= 2) expect_res($sformatf("vec%0d", v-2), tile(vt[v-2].pe), vt[v-2].ovf);
      if (v < 14) drive(vt[v].op, 1'b1, 1'b1, tile(vt[v].pa), tile(vt[v].pb));
      else in_valid = 1'b0;
    end

    // Three-beat op0 chain of all-ones tiles.
    @(negedge clk); drive(3'd0, 1'b1, 1'b0, tile(2), tile(2));
    @(negedge clk); drive(3'd0, 1'b0, 1'b0, tile(2), tile(2));
    @(negedge clk); expect_none("chain3 b1"); drive(3'd0, 1'b0, 1'b1, tile(2), tile(2));
    @(negedge clk); expect_none("chain3 b2"); in_valid = 1'b0;
    @(negedge clk); expect_res("chain3", tile(23), 1'b0);

    // Overflow in the first beat stays sticky through the last.
    @(negedge clk); drive(3'd0, 1'b1, 1'b0, tile(3), tile(3));
    @(negedge clk); drive(3'd0, 1'b0, 1'b1, tile(2), tile(2));
    @(negedge clk); expect_none("sticky b1"); in_valid = 1'b0;
    @(negedge clk); expect_res("sticky", tile(24), 1'b1);

    // in_first mid-chain discards the open chain.
    @(negedge clk); drive(3'd0, 1'b1, 1'b0, tile(2), tile(2));
    @(negedge clk); drive(3'd0, 1'b1, 1'b1, tile(0), tile(1));
    @(negedge clk); expect_none("restart b1"); in_valid = 1'b0;
    @(negedge clk); expect_res("restart", tile(1), 1'b0);
    @(negedge clk); expect_none("restart no dup");

    // Chain op latched on the first beat; op0 on beat 2 is ignored.
    @(negedge clk); drive(3'd5, 1'b1, 1'b0, tile(18), tile(19));
    @(negedge clk); drive(3'd0, 1'b0, 1'b1, tile(2), tile(2));
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); expect_res("op latch", tile(26), 1'b0);

    // Stall: three cycles with out_ready low while beats are queued.
    @(negedge clk); out_ready = 1'b0; drive(3'd0, 1'b1, 1'b1, tile(0), tile(1));
    @(negedge clk); drive(3'd0, 1'b1, 1'b1, tile(0), tile(20));
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (s == 0) drive(3'd0, 1'b1, 1'b1, tile(2), tile(2));
      chk($sformatf("stall%0d in_ready", s), tile_t'(in_ready), tile_t'(0));
      expect_res($sformatf("stall%0d held", s), tile(1), 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", tile_t'(in_ready), tile_t'(1));
    expect_res("release 2nd", tile(20), 1'b0);
    in_valid = 1'b0;
    @(negedge clk); expect_res("release 3rd", tile(24), 1'b0);
    @(negedge clk); expect_none("release no dup");

    // Random tiles for ops 3 and 5 against the reference.
    for (int v = 0; v < 8; v++)
      for (int e = 0; e < N*N; e++) begin
        ra[v][e*W +: W] = 16'($urandom);
        rb[v][e*W +: W] = 16'($urandom);
      end
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      if (v >= 2) expect_res($sformatf("rand%0d", v-2),
                             model((v-2 < 4) ? 3'd3 : 3'd5, ra[v-2], rb[v-2], '0, 1'b1), 1'b0);
      if (v < 8) drive((v < 4) ? 3'd3 : 3'd5, 1'b1, 1'b1, ra[v], rb[v]);
      else in_valid = 1'b0;
    end
    e1 = model(3'd3, ra[0], rb[0], '0, 1'b1);
    e2 = model(3'd3, ra[1], rb[1], e1, 1'b0);
    @(negedge clk); drive(3'd3, 1'b1, 1'b0, ra[0], rb[0]);
    @(negedge clk); drive(3'd5, 1'b0, 1'b1, ra[1], rb[1]);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); expect_res("rand chain", e2, 1'b0);

    // Reset in the middle of a four-beat op3 chain.
    @(negedge clk); drive(3'd3, 1'b1, 1'b0, tile(2), tile(2));
    @(negedge clk); drive(3'd3, 1'b0, 1'b0, tile(2), tile(2));
    @(negedge clk); drive(3'd3, 1'b0, 1'b0, tile(2), tile(2));
    #2; rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midreset out_valid", tile_t'(out_valid), tile_t'(0));
    chk("midreset out_data", out_data, '0);
    chk("midreset in_ready", tile_t'(in_ready), tile_t'(1));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive(3'd0, 1'b0, 1'b1, tile(0), tile(1));
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); expect_res("post reset", tile(1), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
